bcd_counter_mod: RTL
====================

Name: bcd_counter_mod

Overview:
Parametrised multi-digit packed-BCD counter with a run-time programmable terminal value, up/down direction, synchronous load, and cascade outputs. It generalises the fixed two-digit modulo-24 hour counter. One instance covers seconds/minutes (max 59), hours (max 23) or any N-digit decimal modulus, and instances chain via tc/en.

Parameters:
DIGITS, 2, number of BCD digits; dout width = 4*DIGITS; legal range 1..8.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  count enable; sampled on rising edge of clk.
up  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  synchronous load strobe.
load_val  input  4*DIGITS  packed BCD value to load.
max_val  input  4*DIGITS  packed BCD terminal value; the count range is 0..max_val.
dout  output  4*DIGITS  current count, packed BCD; digit 0 in [3:0].
tc  output  1  combinational terminal count, for cascading.
carry  output  1  registered one-cycle wrap/borrow pulse.
load_err  output  1  registered one-cycle pulse: load value rejected.
cfg_err  output  1  combinational: max_val contains a nibble > 9.

Behaviour:
- Reset: rst high drives, asynchronously, dout = 0, carry = 0, load_err = 0. It holds while rst is high. The first update occurs on the first clk rise after rst falls.
- Priority per rising edge: rst > load > en. carry and load_err default to 0 every cycle, so they are single-cycle pulses.
- Magnitude compares use plain unsigned compare of packed values. This is valid because all operands are checked BCD.
- cfg_err = 1 when any max_val nibble > 9. While cfg_err = 1:
  - counting holds (dout unchanged, carry = 0);
  - load is rejected (dout <= 0, load_err = 1).
- Load, when load = 1 and cfg_err = 0:
  - load_val all-valid BCD and load_val <= max_val: dout <= load_val, load_err = 0.
  - otherwise: dout <= 0, load_err = 1.
  - en is ignored in a load cycle.
- en = 0 and load = 0: dout holds.
- Count up (en = 1, up = 1):
  - dout >= max_val: dout <= 0, carry = 1. The >= covers max_val lowered below dout mid-run.
  - otherwise: BCD increment. Digit k increments when all digits below k equal 9; any digit equal to 9 that receives the increment wraps to 0.
- Count down (en = 1, up = 0):
  - dout == 0: dout <= max_val, carry = 1.
  - dout > max_val: dout <= max_val, carry = 0.
  - otherwise: BCD decrement. Digit k decrements when all digits below k equal 0; any digit equal to 0 that receives the decrement becomes 9.
- tc (combinational, cfg_err = 0 only, otherwise 0):
  - up = 1: tc = (dout >= max_val).
  - up = 0: tc = (dout == 0).
  - Cascade rule: the next stage's en = en & tc of this stage. The upper stage therefore steps on the same edge this stage wraps.
- carry is high in the cycle after the wrapping edge, coincident with dout showing the wrapped value. Latency of dout after an en/load edge: same edge (registered output, 1 clk).
- max_val = 0: up or down with en = 1 keeps dout = 0 and pulses carry every enabled cycle.
- Direction may change any cycle. The new direction applies on the next edge with no penalty.
- dout never holds a non-BCD nibble in any state reachable after reset.

Test Plan:
1. DIGITS=2, max_val=8'h23, up=1, en=1 from reset:
   - dout steps 00, 01 … 09, 10 … 23, 00; carry = 1 only in the cycle dout returns to 00; tc = 1 only while dout = 23.
2. max_val=8'h59, dout=00, up=0, en=1:
   - next dout = 59 with carry = 1, then 58; load 8'h10 then one down step gives 09.
3. Load tests:
   - load_val=8'h19 then one up step gives 20.
   - load_val=8'h1A gives dout = 00, load_err = 1 for one cycle.
   - load_val=8'h45 with max 23 gives dout = 00, load_err = 1.
   - load = 1 together with en = 1 gives the loaded value, not value+1.
4. Lower max_val below dout mid-run:
   - dout=45, max_val changes 59→23: next up step gives 00 with carry = 1.
   - same setup with up = 0: next step gives 23 with carry = 0.
5. Hold and config error:
   - en = 0 for 5 cycles: dout constant.
   - max_val=8'h2B: cfg_err = 1, tc = 0, en = 1 holds dout; load gives 00 with load_err = 1.
6. Reset and cascade:
   - assert rst between clk edges at dout = 37: dout = 00 immediately, without waiting for a clock edge.
   - cascade two instances (59 and 23) with en2 = tc1: 23:59 → 00:00 on one edge, both carry pulses high in the same cycle.

Source files
------------

// File: rtl/bcd_counter_mod_if.sv
// Control/status bundle for one bcd_counter_mod stage; master drives controls, slave is the counter.
interface bcd_counter_mod_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   max_val;
  logic [4*DIGITS-1:0]   dout;
  logic                  tc;
  logic                  carry;
  logic                  load_err;
  logic                  cfg_err;

  modport master (
    output en, up, load, load_val, max_val,
    input  dout, tc, carry, load_err, cfg_err
  );

  modport slave (
    input  en, up, load, load_val, max_val,
    output dout, tc, carry, load_err, cfg_err
  );
endinterface

// File: rtl/bcd_counter_mod.sv
// Multi-digit packed-BCD up/down counter with programmable terminal value, load and cascade outputs.
// Per-digit step logic lives in bcd_digit; digits ripple an increment/decrement enable upward.
module bcd_digit (
  input  logic [3:0] d_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] inc_o,
  output logic [3:0] dec_o,
  output logic       inc_co,
  output logic       dec_bo
);
  assign inc_co = inc_i & (d_i == 4'd9);
  assign dec_bo = dec_i & (d_i == 4'd0);
  assign inc_o  = !inc_i ? d_i : ((d_i == 4'd9) ? 4'd0 : d_i + 4'd1);
  assign dec_o  = !dec_i ? d_i : ((d_i == 4'd0) ? 4'd9 : d_i - 4'd1);
endmodule

module bcd_counter_mod #(
  parameter int DIGITS = 2
) (
  input logic               clk,
  input logic               rst,
  bcd_counter_mod_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]      cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              lerr_q, lerr_d;

  logic [DIGITS:0]   inc_c, dec_c;
  logic [W-1:0]      inc_v, dec_v;
  logic [DIGITS-1:0] max_bad, ld_bad;
  logic              cfg_err, ld_ok, at_max, is_zero;

  assign inc_c[0] = 1'b1;
  assign dec_c[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .d_i    (cnt_q[4*g +: 4]),
      .inc_i  (inc_c[g]),
      .dec_i  (dec_c[g]),
      .inc_o  (inc_v[4*g +: 4]),
      .dec_o  (dec_v[4*g +: 4]),
      .inc_co (inc_c[g+1]),
      .dec_bo (dec_c[g+1])
    );
    assign max_bad[g] = bus.max_val[4*g +: 4]  > 4'd9;
    assign ld_bad[g]  = bus.load_val[4*g +: 4] > 4'd9;
  end

  // Packed unsigned compares are exact because every operand here is checked BCD.
  assign cfg_err = |max_bad;
  assign ld_ok   = ~|ld_bad && (bus.load_val <= bus.max_val);
  // Borrow out of the top digit means every digit is 0; carry out means all 9s.
  assign is_zero = dec_c[DIGITS];
  assign at_max  = inc_c[DIGITS] || (cnt_q >= bus.max_val);

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    lerr_d  = 1'b0;
    if (bus.load) begin
      if (!cfg_err && ld_ok) begin
        cnt_d = bus.load_val;
      end else begin
        cnt_d  = '0;
        lerr_d = 1'b1;
      end
    end else if (bus.en && !cfg_err) begin
      if (bus.up) begin
        if (at_max) begin
          cnt_d   = '0;
          carry_d = 1'b1;
        end else begin
          cnt_d = inc_v;
        end
      end else if (is_zero) begin
        cnt_d   = bus.max_val;
        carry_d = 1'b1;
      end else if (cnt_q > bus.max_val) begin
        cnt_d = bus.max_val;
      end else begin
        cnt_d = dec_v;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      lerr_q  <= lerr_d;
    end
  end

  assign bus.dout     = cnt_q;
  assign bus.carry    = carry_q;
  assign bus.load_err = lerr_q;
  assign bus.cfg_err  = cfg_err;
  assign bus.tc       = !cfg_err && (bus.up ? at_max : is_zero);
endmodule
